// File: rtl/mnist_pkg.sv
// Shared types and sizing helpers for the maxpool scheduler slice of the mnist_nn datapath.
package mnist_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } sched_state_e;

    // 2x2 window, stride 2: odd trailing row/column is discarded.
    function automatic int n_out(input int img_w, input int img_h);
        return (img_w / 2) * (img_h / 2);
    endfunction

    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // One spare bit so the result counter can hold N_OUT itself.
    function automatic int oa_width(input int img_w, input int img_h);
        return $clog2(n_out(img_w, img_h)) + 1;
    endfunction

endpackage

// File: rtl/maxpool_scheduler_arb.sv
// Combinational round-robin arbiter: first request strictly after the last-grant pointer wins.
module rr_arbiter
    import mnist_pkg::*;
#(
    parameter int N_CH = 4,
    localparam int CH_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] i_req,
    input  logic [CH_W-1:0] i_last,
    output logic [N_CH-1:0] o_gnt,
    output logic [CH_W-1:0] o_gnt_idx,
    output logic            o_any
);

    logic [CH_W-1:0] w_pos;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        w_pos     = '0;
        // Scan N_CH positions starting one past i_last; i_last itself is visited last.
        for (int k = 1; k <= N_CH; k++) begin
            w_pos = CH_W'((int'(i_last) + k) % N_CH);
            if (!o_any && i_req[w_pos]) begin
                o_any         = 1'b1;
                o_gnt[w_pos]  = 1'b1;
                o_gnt_idx     = w_pos;
            end
        end
    end

endmodule

// File: rtl/maxpool_scheduler.sv
// Time-shares one max-pooling engine across N_CH feature-map channels, round-robin per map.
// Optional MAXPOOL_SCHED_PERF_EN adds busy_cycles / maps_done statistics ports.
module maxpool_scheduler
    import mnist_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int IMG_W         = 5,
    parameter int IMG_H         = 5,
    parameter int DRAIN_TIMEOUT = 64,
    localparam int CH_W = ch_width(N_CH),
    localparam int IA_W = $clog2(IMG_W * IMG_H),
    localparam int OA_W = oa_width(IMG_W, IMG_H)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    output logic [N_CH-1:0] done,
    output logic            rd_en,
    output logic [CH_W-1:0] rd_ch,
    output logic [IA_W-1:0] rd_addr,
    input  logic            rd_data,
    output logic            pool_clr,
    output logic            pool_valid_in,
    output logic            pool_pixel_in,
    input  logic            pool_valid_out,
    input  logic            pool_out,
    output logic            wr_en,
    output logic [CH_W-1:0] wr_ch,
    output logic [OA_W-1:0] wr_addr,
    output logic            wr_data,
`ifdef MAXPOOL_SCHED_PERF_EN
    output logic [31:0]     busy_cycles,
    output logic [15:0]     maps_done,
`endif
    output logic            timeout_err
);

    localparam int              N_OUT     = n_out(IMG_W, IMG_H);
    localparam int              DT_W      = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [IA_W-1:0] LAST_ADDR = IA_W'(IMG_W * IMG_H - 1);
    localparam logic [OA_W-1:0] N_OUT_C   = OA_W'(N_OUT);
    localparam logic [DT_W-1:0] DT_LAST   = DT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CH_W-1:0] PTR_RST   = CH_W'(N_CH - 1);

    sched_state_e    r_state, w_next;
    logic [CH_W-1:0] r_rr, r_cur_ch, w_gnt_idx;
    logic [N_CH-1:0] r_cur_oh, w_gnt;
    logic            w_any;
    logic [IA_W-1:0] r_addr;
    logic            r_vld;
    logic [OA_W-1:0] r_out_cnt;
    logic [DT_W-1:0] r_drain_cnt;
    logic            r_timeout;
    logic            w_capture, w_full, w_expire;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .i_req     (req),
        .i_last    (r_rr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    assign w_full    = (r_out_cnt == N_OUT_C);
    assign w_expire  = (r_drain_cnt == DT_LAST);
    // Engine results are only trusted while a map is in flight and room remains.
    assign w_capture = ((r_state == STREAM) || (r_state == DRAIN)) && pool_valid_out
                       && (r_out_cnt < N_OUT_C);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = CLEAR;
            CLEAR:   w_next = STREAM;
            STREAM:  if (r_addr == LAST_ADDR) w_next = DRAIN;
            DRAIN:   if (w_full || w_expire) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr        <= PTR_RST;
            r_cur_ch    <= '0;
            r_cur_oh    <= '0;
            r_addr      <= '0;
            r_vld       <= 1'b0;
            r_out_cnt   <= '0;
            r_drain_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_vld   <= (r_state == STREAM);
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_cur_ch    <= w_gnt_idx;
                        r_cur_oh    <= w_gnt;
                        r_addr      <= '0;
                        r_out_cnt   <= '0;
                        r_drain_cnt <= '0;
                    end
                end
                CLEAR:  r_rr <= r_cur_ch;
                STREAM: r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
                DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + 1'b1;
                    if (!w_full && w_expire) r_timeout <= 1'b1;
                end
                default: ;
            endcase
            if (w_capture) r_out_cnt <= r_out_cnt + 1'b1;
        end
    end

    // All outputs decode from reset-cleared state, so rst forces them low immediately.
    always_comb begin
        rd_en         = (r_state == STREAM);
        rd_ch         = rd_en ? r_cur_ch : '0;
        rd_addr       = rd_en ? r_addr : '0;
        pool_clr      = (r_state == CLEAR);
        pool_valid_in = r_vld;
        pool_pixel_in = r_vld & rd_data;
        wr_en         = w_capture;
        wr_ch         = w_capture ? r_cur_ch : '0;
        wr_addr       = w_capture ? r_out_cnt : '0;
        wr_data       = w_capture & pool_out;
        done          = (r_state == DONE) ? r_cur_oh : '0;
        timeout_err   = r_timeout;
    end

`ifdef MAXPOOL_SCHED_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cycles <= '0;
            maps_done   <= '0;
        end else begin
            if ((r_state != IDLE) && (busy_cycles != '1)) busy_cycles <= busy_cycles + 1'b1;
            if (r_state == DONE) maps_done <= maps_done + 1'b1;
        end
    end
`else
    // Statistics build option off: no counters are kept.
`endif

endmodule

// File: tb/tb_maxpool_scheduler.sv
// Self-checking bench: buffer + engine models around the scheduler, reference pooling/RR model.
module tb_maxpool_scheduler;
    localparam int N_CH = 4, W = 5, H = 5, NPIX = W * H, NOUT = (W / 2) * (H / 2);

    logic clk = 1'b0, rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] done;
    logic rd_en, rd_data = 1'b0, pool_clr, pool_valid_in, pool_pixel_in;
    logic pool_valid_out, pool_out, wr_en, wr_data, timeout_err;
    logic [1:0] rd_ch, wr_ch;
    logic [4:0] rd_addr;
    logic [2:0] wr_addr;
`ifdef MAXPOOL_SCHED_PERF_EN
    logic [31:0] busy_cycles;
    logic [15:0] maps_done;
`endif

    always #5 clk = ~clk;

    maxpool_scheduler dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data),
        .pool_clr(pool_clr), .pool_valid_in(pool_valid_in), .pool_pixel_in(pool_pixel_in),
        .pool_valid_out(pool_valid_out), .pool_out(pool_out),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef MAXPOOL_SCHED_PERF_EN
        .busy_cycles(busy_cycles), .maps_done(maps_done),
`endif
        .timeout_err(timeout_err)
    );

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    logic [NPIX-1:0] fmap [N_CH];

    // Feature buffer: registered read, data one cycle after rd_en.
    always @(posedge clk) rd_data <= rd_en ? fmap[rd_ch][rd_addr] : 1'b0;

    // Engine model: accumulates 2x2 blocks, emits each result after the block's last pixel.
    int eng_idx = 0, eng_emit = 0, eng_limit = 4;
    logic [NOUT-1:0] eng_acc = '0;
    logic eng_ov = 1'b0, eng_od = 1'b0, inj_v = 1'b0, inj_d = 1'b0;

    function automatic int slot_of(input int i);
        int r, c;
        r = i / W; c = i % W;
        if (r >= 2 * (H / 2) || c >= 2 * (W / 2)) return -1;
        return (r / 2) * (W / 2) + c / 2;
    endfunction

    function automatic bit corner(input int i);
        return ((i / W) % 2 == 1) && ((i % W) % 2 == 1) && slot_of(i) >= 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || pool_clr) begin
            eng_idx <= 0; eng_emit <= 0; eng_acc <= '0; eng_ov <= 1'b0; eng_od <= 1'b0;
        end else begin
            eng_ov <= 1'b0;
            if (pool_valid_in) begin
                eng_idx <= eng_idx + 1;
                if (slot_of(eng_idx) >= 0) begin
                    eng_acc[slot_of(eng_idx)] <= eng_acc[slot_of(eng_idx)] | pool_pixel_in;
                    if (corner(eng_idx) && eng_emit < eng_limit) begin
                        eng_ov   <= 1'b1;
                        eng_od   <= eng_acc[slot_of(eng_idx)] | pool_pixel_in;
                        eng_emit <= eng_emit + 1;
                    end
                end
            end
        end
    end

    assign pool_valid_out = eng_ov | inj_v;
    assign pool_out       = eng_ov ? eng_od : inj_d;

    typedef struct { int cyc; int ch; int addr; int data; } ev_t;
    ev_t rd_q[$], wr_q[$], dn_q[$];
    int overlap = 0;

    function automatic int oh_idx(input logic [3:0] v);
        int n = 0, idx = -1;
        for (int i = 0; i < N_CH; i++) if (v[i]) begin n++; idx = i; end
        return (n == 1) ? idx : -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en) rd_q.push_back('{cyc, int'(rd_ch), int'(rd_addr), 0});
            if (wr_en) wr_q.push_back('{cyc, int'(wr_ch), int'(wr_addr), int'(wr_data)});
            if (done != 0) dn_q.push_back('{cyc, oh_idx(done), 0, int'(done)});
            if (rd_en && done != 0) overlap++;
        end
    end

    // Reference: pooled value = OR of the 2x2 block at output k.
    function automatic bit ref_pool(input int ch, input int k);
        int i, j;
        i = k / (W / 2); j = k % (W / 2);
        return fmap[ch][(2*i)*W + 2*j] | fmap[ch][(2*i)*W + 2*j + 1]
             | fmap[ch][(2*i+1)*W + 2*j] | fmap[ch][(2*i+1)*W + 2*j + 1];
    endfunction

    function automatic int rr_next(input int ptr, input logic [3:0] m);
        for (int k = 1; k <= N_CH; k++) if (m[(ptr + k) % N_CH]) return (ptr + k) % N_CH;
        return -1;
    endfunction

    task automatic do_reset();
        #2 rst = 1'b1; req = '0; inj_v = 1'b0; inj_d = 1'b0; eng_limit = 4;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        rd_q.delete(); wr_q.delete(); dn_q.delete(); overlap = 0;
    endtask

    task automatic wait_done(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (dn_q.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    function automatic void rand_maps();
        for (int c = 0; c < N_CH; c++) fmap[c] = NPIX'({$urandom, $urandom});
    endfunction

    // Counts writes of grant g (slots g*NOUT..) that disagree with the reference for channel ch.
    function automatic int bad_writes(input int g, input int ch);
        int b = 0;
        for (int k = 0; k < NOUT; k++) begin
            if (g * NOUT + k >= wr_q.size()) b++;
            else if (wr_q[g*NOUT+k].ch != ch || wr_q[g*NOUT+k].addr != k
                     || wr_q[g*NOUT+k].data != int'(ref_pool(ch, k))) b++;
        end
        return b;
    endfunction

    function automatic int bad_reads(input int g, input int ch);
        int b = 0;
        for (int a = 0; a < NPIX; a++) begin
            if (g * NPIX + a >= rd_q.size()) b++;
            else if (rd_q[g*NPIX+a].ch != ch || rd_q[g*NPIX+a].addr != a
                     || rd_q[g*NPIX+a].cyc != rd_q[g*NPIX].cyc + a) b++;
        end
        return b;
    endfunction

    task automatic test_reset();
        logic [31:0] v;
        #2 rst = 1'b1; #1;
        v = {done, rd_en, rd_ch, rd_addr, pool_clr, pool_valid_in, pool_pixel_in,
             wr_en, wr_ch, wr_addr, wr_data, timeout_err};
        n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL reset_outputs got %h want 0", v); end
        do_reset();
        repeat (3) @(posedge clk); #2;
        n_cmp++;
        if (rd_en !== 1'b0 || pool_clr !== 1'b0 || done !== 4'd0) begin
            n_bad++; $display("FAIL idle_quiet rd_en=%b clr=%b done=%b want 0", rd_en, pool_clr, done);
        end
    endtask

    task automatic test_checkerboard();
        bit ok; int rc, b;
        do_reset();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) fmap[0][r*W+c] = ((r + c) % 2 == 1);
        req = 4'b0001; rc = cyc;
        wait_done(1, 200, ok);
        req = '0;
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL cb_done_timeout got %0d dones want 1", dn_q.size()); end
        b = bad_reads(0, 0);
        n_cmp++; if (b != 0 || rd_q.size() != NPIX) begin n_bad++; $display("FAIL cb_reads bad=%0d n=%0d want 0/%0d", b, rd_q.size(), NPIX); end
        b = bad_writes(0, 0);
        n_cmp++; if (b != 0 || wr_q.size() != NOUT) begin n_bad++; $display("FAIL cb_writes bad=%0d n=%0d want 0/%0d", b, wr_q.size(), NOUT); end
        n_cmp++; if (wr_q.size() > 0 && wr_q[0].data != 1) begin n_bad++; $display("FAIL cb_data got %0d want 1", wr_q[0].data); end
        if (ok) begin
            n_cmp++; if (dn_q[0].data != 1) begin n_bad++; $display("FAIL cb_done_vec got %0d want 1", dn_q[0].data); end
            n_cmp++; if (dn_q[0].cyc - rc < NPIX + 3) begin n_bad++; $display("FAIL cb_done_lat got %0d want >=%0d", dn_q[0].cyc - rc, NPIX + 3); end
        end
        if (rd_q.size() > 0) begin
            n_cmp++; if (rd_q[0].cyc - rc != 2) begin n_bad++; $display("FAIL cb_rd_lat got %0d want 2", rd_q[0].cyc - rc); end
        end
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL cb_timeout got %b want 0", timeout_err); end
    endtask

    task automatic test_round_robin();
        bit ok; int ptr, exp, bad;
        do_reset(); rand_maps();
        req = 4'b1111;
        wait_done(5, 400, ok);
        req = '0;
        repeat (4) @(posedge clk); #2;
        n_cmp++; if (!ok || dn_q.size() != 5) begin n_bad++; $display("FAIL rr_count got %0d want 5", dn_q.size()); end
        ptr = N_CH - 1; bad = 0;
        for (int g = 0; g < 5 && g < dn_q.size(); g++) begin
            exp = rr_next(ptr, 4'b1111); ptr = exp;
            if (dn_q[g].ch != exp || bad_reads(g, exp) != 0 || bad_writes(g, exp) != 0) bad++;
            if (g > 0 && dn_q[g].cyc == dn_q[g-1].cyc + 1) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rr_order_data bad_grants=%0d want 0", bad); end
        n_cmp++; if (overlap != 0) begin n_bad++; $display("FAIL rr_overlap got %0d want 0", overlap); end
    endtask

    task automatic test_late_req();
        bit ok; int bad;
        do_reset(); rand_maps();
        req = 4'b0101;
        for (int i = 0; i < 100 && rd_q.size() < 6; i++) begin @(posedge clk); #2; end
        req = 4'b0111;
        wait_done(3, 400, ok);
        req = '0;
        bad = 0;
        for (int g = 0; g < 3; g++)
            if (g >= dn_q.size() || dn_q[g].ch != g || bad_writes(g, g) != 0) bad++;
        n_cmp++; if (!ok || bad != 0) begin n_bad++; $display("FAIL late_req_order bad=%0d dones=%0d want 0/3", bad, dn_q.size()); end
    endtask

    task automatic test_random();
        bit ok; int ptr, exp, bad;
        logic [3:0] m;
        do_reset(); rand_maps();
        ptr = N_CH - 1; bad = 0;
        for (int it = 0; it < 8; it++) begin
            m = 4'($urandom_range(1, 15));
            req = m;
            exp = rr_next(ptr, m); ptr = exp;
            wait_done(it + 1, 200, ok);
            if (!ok || dn_q[it].ch != exp || bad_reads(it, exp) != 0 || bad_writes(it, exp) != 0) bad++;
        end
        req = '0;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL random_rr bad_grants=%0d want 0", bad); end
    endtask

    task automatic test_timeout();
        bit ok; int rc;
        do_reset(); rand_maps();
        eng_limit = 3;
        req = 4'b0001; rc = cyc;
        wait_done(1, 300, ok);
        req = '0;
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL to_done got %0d dones want 1", dn_q.size()); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_flag got %b want 1", timeout_err); end
        n_cmp++; if (wr_q.size() != 3) begin n_bad++; $display("FAIL to_writes got %0d want 3", wr_q.size()); end
        if (ok) begin
            n_cmp++;
            if (dn_q[0].cyc - rc != 1 + NPIX + 64 + 1) begin
                n_bad++; $display("FAIL to_latency got %0d want %0d", dn_q[0].cyc - rc, NPIX + 66);
            end
        end
        eng_limit = 4;
        repeat (2) @(posedge clk); #2;
        req = 4'b0001;
        wait_done(2, 200, ok);
        req = '0;
        n_cmp++; if (!ok || timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_sticky got %b ok=%0d want 1", timeout_err, ok); end
    endtask

    task automatic test_reset_mid();
        bit ok, hit; logic [31:0] v;
        do_reset(); rand_maps();
        req = 4'b0001; hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(posedge clk); #1;
            if (rd_en && rd_addr == 5'd10) hit = 1'b1;
        end
        n_cmp++; if (!hit) begin n_bad++; $display("FAIL mid_reach got none want addr 10"); end
        #1 rst = 1'b1; #1;
        v = {done, rd_en, rd_ch, rd_addr, pool_clr, pool_valid_in, pool_pixel_in,
             wr_en, wr_ch, wr_addr, wr_data, timeout_err};
        n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL mid_async got %h want 0", v); end
        repeat (3) @(posedge clk); #2;
        n_cmp++; if (dn_q.size() != 0) begin n_bad++; $display("FAIL mid_no_done got %0d want 0", dn_q.size()); end
        rd_q.delete(); wr_q.delete(); dn_q.delete();
        rst = 1'b0;
        wait_done(1, 200, ok);
        req = '0;
        n_cmp++;
        if (!ok || bad_reads(0, 0) != 0 || bad_writes(0, 0) != 0) begin
            n_bad++; $display("FAIL mid_restart first_addr=%0d ok=%0d want 0/1", rd_q.size() ? rd_q[0].addr : -1, ok);
        end
    endtask

    task automatic test_spurious();
        bit ok, hit;
        do_reset(); rand_maps();
        repeat (2) @(posedge clk); #2;
        inj_v = 1'b1; inj_d = 1'b1;
        repeat (3) @(posedge clk); #2;
        inj_v = 1'b0;
        n_cmp++; if (wr_q.size() != 0) begin n_bad++; $display("FAIL spur_idle got %0d writes want 0", wr_q.size()); end
        req = 4'b0001; hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(posedge clk); #1;
            if (pool_valid_in && !rd_en) hit = 1'b1;
        end
        inj_v = 1'b1; inj_d = 1'b1; #1;
        n_cmp++; if (!hit || wr_en !== 1'b0) begin n_bad++; $display("FAIL spur_drain wr_en=%b hit=%0d want 0/1", wr_en, hit); end
        @(posedge clk); #1 inj_v = 1'b0;
        wait_done(1, 100, ok);
        req = '0;
        n_cmp++;
        if (!ok || wr_q.size() != NOUT || bad_writes(0, 0) != 0) begin
            n_bad++; $display("FAIL spur_writes got %0d want %0d", wr_q.size(), NOUT);
        end
    endtask

    initial begin
        test_reset();
        test_checkerboard();
        test_round_robin();
        test_late_req();
        test_random();
        test_timeout();
        test_reset_mid();
        test_spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
